bet_capture_fsm: RTL and testbench
==================================

Name: bet_capture_fsm

Overview:
- Captures roulette bets from the keyboard bet-opcode path and the Arduino colour inputs, then drives the regfile bet ports (bet1..bet12) and spin_check.
- Sits between the PS/2 controller and opcode decoder upstream and the regfile downstream.
- Replaces the free-running bet counter and latch in the top level with a locked bet window: bets are accepted only while the table is open, frozen during a spin, and cleared after settlement.

Parameters:
MAX_BETS, 12, number of bet slots (1..15).
SPIN_OP, 6'b111110, opcode that starts a spin.
CLEAR_OP, 6'b111111, opcode that discards all pending bets.
HOLD_CYCLES, 16, cycles bets stay visible in SETTLE for payout evaluation (>=1).

Ports:
clock  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
read_data  in  1  PS/2 new-scan indicator (level or pulse); rising edge = one keypress event.
bet_opcode  in  6  decoded bet opcode, valid while read_data is high.
arduino_color  in  3  chip colour from Arduino; 3'b000 = no chip.
spin_done  in  1  one-cycle pulse when the wheel has stopped.
bet_flat  out  8*MAX_BETS  slot k at [8k+7:8k] = {color[1:0], opcode}; unused slots 8'h00.
bet_count  out  4  number of valid slots, 0..MAX_BETS.
full  out  1  bet_count == MAX_BETS.
spin_check  out  1  high throughout SPIN state.
bet_accept  out  1  one-cycle pulse: event stored.
bet_reject  out  1  one-cycle pulse: event discarded.
state_dbg  out  2  current state encoding (OPEN=0, SPIN=1, SETTLE=2).

Behaviour:
- Reset (async, immediate): state=OPEN; all slots 8'h00; bet_count=0; full=0; spin_check=0; bet_accept=0; bet_reject=0; hold counter=0; read_data_q=0.
- Edge detect: read_data_q registers read_data. strobe = read_data & ~read_data_q. A held read_data produces exactly one event.
- Latency: the event is processed on the clock edge where strobe=1. Slot, count and state update on that edge. bet_accept/bet_reject are registered and high for the single following cycle. The two pulses are never both high.
- OPEN state, on strobe, evaluated in priority order:
  1. opcode==CLEAR_OP: all slots 8'h00, count=0, accept pulse.
  2. opcode==SPIN_OP: if count>0, go to SPIN with accept pulse; if count==0, reject pulse and stay in OPEN.
  3. arduino_color==3'b000: reject.
  4. full: reject; slots unchanged, no wrap-around.
  5. Duplicate: combined byte equals any slot index < count: reject.
  6. Otherwise: slot[count] <= {arduino_color[1:0], bet_opcode}; count+1; accept pulse.
- SPIN: spin_check=1. Every strobe produces a reject pulse, including CLEAR_OP and SPIN_OP; slots are frozen. spin_done moves to SETTLE on that edge.
- SETTLE: spin_check=0; slots and count still valid. Hold counter counts 0..HOLD_CYCLES-1. On the edge where the counter equals HOLD_CYCLES-1: all slots 8'h00, count=0, state=OPEN. Strobes in SETTLE produce reject pulses.
- spin_done outside SPIN is ignored.
- If strobe and spin_done arrive in the same cycle in SPIN, the transition is taken and the strobe is rejected.
- Reset asserted mid-spin or mid-settle returns to OPEN with empty slots; no pulse is emitted.
- full and bet_count are registered; both are combinational-free of inputs.

Test Plan:
- Reset, then three rising edges of read_data with colors 3'b001/010/011 and opcodes 6'd5/6'd7/6'd9 -> bet_flat[23:0]=24'hC9_87_45, bet_count=3, three accept pulses.
- Hold read_data high 10 cycles with opcode 6'd5, color 3'b001 -> exactly one accept; a second press of the same values -> reject, count stays 1.
- Fill 12 distinct bets, press a 13th -> reject, full=1, slot 11 unchanged. Press CLEAR_OP -> count=0, bet_flat all zero, accept.
- Empty table, press SPIN_OP -> reject, state_dbg=0. Two bets, then SPIN_OP -> spin_check=1 the cycle after. Bet press in SPIN -> reject, count=2.
- In SPIN, pulse spin_done -> state_dbg=2, bets retained exactly HOLD_CYCLES=16 cycles, then cleared, state_dbg=0, spin_check=0.
- Assert reset asynchronously mid-SETTLE (between clock edges) -> outputs zero immediately. A bet pressed after release is accepted into slot 0.

Source files
------------

// File: rtl/bet_capture_if.sv
// Bet capture bus: keypress/colour/spin inputs from the upstream PS/2,
// opcode decoder and Arduino path, and the bet table outputs that feed the
// regfile bet ports and spin_check.
//   master : upstream/regfile side (drives read_data, bet_opcode,
//            arduino_color, spin_done; observes the table outputs)
//   slave  : bet_capture_fsm
interface bet_capture_if #(
    parameter int MAX_BETS = 12
);
    logic                    read_data;
    logic [5:0]              bet_opcode;
    logic [2:0]              arduino_color;
    logic                    spin_done;
    logic [8*MAX_BETS-1:0]   bet_flat;
    logic [3:0]              bet_count;
    logic                    full;
    logic                    spin_check;
    logic                    bet_accept;
    logic                    bet_reject;
    logic [1:0]              state_dbg;

    modport master (
        output read_data, bet_opcode, arduino_color, spin_done,
        input  bet_flat, bet_count, full, spin_check, bet_accept, bet_reject, state_dbg
    );

    modport slave (
        input  read_data, bet_opcode, arduino_color, spin_done,
        output bet_flat, bet_count, full, spin_check, bet_accept, bet_reject, state_dbg
    );
endinterface

// File: rtl/bet_capture_fsm.sv
// Roulette bet capture with a locked bet window.
// Bets are taken from keypress events only while the table is OPEN, frozen
// while the wheel spins, held for HOLD_CYCLES in SETTLE for payout
// evaluation, then cleared.
// Ports:
//   clock, reset     : system clock, asynchronous active-high reset
//   bus (slave)      : read_data/bet_opcode/arduino_color/spin_done in;
//                      bet_flat (slot k at [8k+7:8k] = {color[1:0],opcode}),
//                      bet_count, full, spin_check, bet_accept, bet_reject,
//                      state_dbg out. All outputs come straight from flops.
module bet_capture_fsm #(
    parameter int         MAX_BETS    = 12,
    parameter logic [5:0] SPIN_OP     = 6'b111110,
    parameter logic [5:0] CLEAR_OP    = 6'b111111,
    parameter int         HOLD_CYCLES = 16
) (
    input  logic          clock,
    input  logic          reset,
    bet_capture_if.slave  bus
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] S_OPEN   = 2'd0;
    localparam logic [1:0] S_SPIN   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]                r_state,  w_state_n;
    logic [MAX_BETS-1:0][7:0]  r_slot,   w_slot_n;
    logic [3:0]                r_count,  w_count_n;
    logic                      r_full,   w_full_n;
    logic [HW-1:0]             r_hold,   w_hold_n;
    logic                      r_accept, w_accept_n;
    logic                      r_reject, w_reject_n;
    logic                      r_read_data_q;

    logic                      w_strobe;
    logic [7:0]                w_byte;
    logic                      w_dup;

    // A held read_data level yields a single event on its rising edge.
    assign w_strobe = bus.read_data & ~r_read_data_q;
    assign w_byte   = {bus.arduino_color[1:0], bus.bet_opcode};

    // Only occupied slots take part in the duplicate check: colour 3'b100
    // maps to byte bits 00, which could otherwise match an empty slot.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < MAX_BETS; i++) begin
            if (i < int'(r_count) && r_slot[i] == w_byte)
                w_dup = 1'b1;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_slot_n   = r_slot;
        w_count_n  = r_count;
        w_hold_n   = r_hold;
        w_accept_n = 1'b0;
        w_reject_n = 1'b0;

        case (r_state)
            S_OPEN: begin
                if (w_strobe) begin
                    if (bus.bet_opcode == CLEAR_OP) begin
                        w_slot_n   = '0;
                        w_count_n  = 4'd0;
                        w_accept_n = 1'b1;
                    end else if (bus.bet_opcode == SPIN_OP) begin
                        if (r_count != 4'd0) begin
                            w_state_n  = S_SPIN;
                            w_accept_n = 1'b1;
                        end else begin
                            w_reject_n = 1'b1;
                        end
                    end else if (bus.arduino_color == 3'b000 || r_full || w_dup) begin
                        w_reject_n = 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_BETS; i++) begin
                            if (i == int'(r_count))
                                w_slot_n[i] = w_byte;
                        end
                        w_count_n  = r_count + 4'd1;
                        w_accept_n = 1'b1;
                    end
                end
            end

            S_SPIN: begin
                // Table is locked: every keypress is refused, even CLEAR/SPIN.
                if (w_strobe)
                    w_reject_n = 1'b1;
                if (bus.spin_done) begin
                    w_state_n = S_SETTLE;
                    w_hold_n  = '0;
                end
            end

            S_SETTLE: begin
                if (w_strobe)
                    w_reject_n = 1'b1;
                if (r_hold == HW'(HOLD_CYCLES - 1)) begin
                    w_slot_n  = '0;
                    w_count_n = 4'd0;
                    w_hold_n  = '0;
                    w_state_n = S_OPEN;
                end else begin
                    w_hold_n  = r_hold + 1'b1;
                end
            end

            default: begin
                w_state_n = S_OPEN;
                w_slot_n  = '0;
                w_count_n = 4'd0;
                w_hold_n  = '0;
            end
        endcase

        w_full_n = (w_count_n == 4'(MAX_BETS));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_OPEN;
            r_slot        <= '0;
            r_count       <= 4'd0;
            r_full        <= 1'b0;
            r_hold        <= '0;
            r_accept      <= 1'b0;
            r_reject      <= 1'b0;
            r_read_data_q <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_slot        <= w_slot_n;
            r_count       <= w_count_n;
            r_full        <= w_full_n;
            r_hold        <= w_hold_n;
            r_accept      <= w_accept_n;
            r_reject      <= w_reject_n;
            r_read_data_q <= bus.read_data;
        end
    end

    assign bus.bet_flat   = r_slot;
    assign bus.bet_count  = r_count;
    assign bus.full       = r_full;
    assign bus.spin_check = (r_state == S_SPIN);
    assign bus.bet_accept = r_accept;
    assign bus.bet_reject = r_reject;
    assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_bet_capture_fsm.sv
// Bench for bet_capture_fsm: directed walk through the bet window plus a
// randomized phase, every cycle checked against a queue-based table model.
module tb_bet_capture_fsm;

    localparam int         MAX      = 12;
    localparam int         HOLD     = 16;
    localparam logic [5:0] SPIN_OP  = 6'b111110;
    localparam logic [5:0] CLEAR_OP = 6'b111111;

    logic clock;
    logic reset;

    bet_capture_if #(.MAX_BETS(MAX)) bus ();

    bet_capture_fsm #(
        .MAX_BETS    (MAX),
        .SPIN_OP     (SPIN_OP),
        .CLEAR_OP    (CLEAR_OP),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int acc_seen = 0;
    int rej_seen = 0;

    // Reference model: the table is a queue of accepted bet bytes; mode is
    // 0 open, 1 spinning, 2 settling; m_left counts settle cycles remaining.
    logic [7:0] m_bets[$];
    int         m_mode;
    int         m_left;
    bit         m_prev;
    bit         m_acc;
    bit         m_rej;

    function automatic void m_reset();
        m_bets.delete();
        m_mode = 0;
        m_left = 0;
        m_prev = 0;
        m_acc  = 0;
        m_rej  = 0;
    endfunction

    function automatic void model_edge(bit rd, logic [5:0] op, logic [2:0] col, bit sd);
        bit         strobe;
        bit         dup;
        logic [7:0] b;
        strobe = rd && !m_prev;
        m_prev = rd;
        m_acc  = 0;
        m_rej  = 0;
        b      = {col[1:0], op};
        if (m_mode == 0) begin
            if (strobe) begin
                if (op == CLEAR_OP) begin
                    m_bets.delete();
                    m_acc = 1;
                end else if (op == SPIN_OP) begin
                    if (m_bets.size() > 0) begin m_mode = 1; m_acc = 1; end
                    else m_rej = 1;
                end else if (col == 3'b000 || m_bets.size() >= MAX) begin
                    m_rej = 1;
                end else begin
                    dup = 0;
                    foreach (m_bets[i]) if (m_bets[i] == b) dup = 1;
                    if (dup) m_rej = 1;
                    else begin m_bets.push_back(b); m_acc = 1; end
                end
            end
        end else if (m_mode == 1) begin
            if (strobe) m_rej = 1;
            if (sd) begin m_mode = 2; m_left = HOLD; end
        end else begin
            if (strobe) m_rej = 1;
            m_left--;
            if (m_left == 0) begin m_bets.delete(); m_mode = 0; end
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [8*MAX-1:0] ef;
        ef = '0;
        foreach (m_bets[i]) ef[8*i +: 8] = m_bets[i];
        chk("bet_flat",   bus.bet_flat, ef);
        chk("bet_count",  bus.bet_count, m_bets.size());
        chk("full",       bus.full, (m_bets.size() == MAX));
        chk("spin_check", bus.spin_check, (m_mode == 1));
        chk("bet_accept", bus.bet_accept, m_acc);
        chk("bet_reject", bus.bet_reject, m_rej);
        chk("state_dbg",  bus.state_dbg, m_mode);
        chk("pulse_excl", bus.bet_accept & bus.bet_reject, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge(bus.read_data, bus.bet_opcode, bus.arduino_color, bus.spin_done);
        #1;
        check_all();
        if (bus.bet_accept) acc_seen++;
        if (bus.bet_reject) rej_seen++;
    endtask

    task automatic press(input logic [5:0] op, input logic [2:0] col);
        bus.bet_opcode    = op;
        bus.arduino_color = col;
        bus.read_data     = 1'b1;
        tick();
        bus.read_data     = 1'b0;
        tick();
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset();
        @(negedge clock);
        bus.read_data = 1'b0;
        bus.spin_done = 1'b0;
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int a0;
        int r0;
        logic [8*MAX-1:0] f;

        reset             = 1'b1;
        bus.read_data     = 1'b0;
        bus.bet_opcode    = 6'd0;
        bus.arduino_color = 3'd0;
        bus.spin_done     = 1'b0;
        m_reset();
        #2;
        check_all();
        #10;
        reset = 1'b0;

        // Three distinct bets land in slots 0..2.
        a0 = acc_seen;
        press(6'd5, 3'b001);
        press(6'd7, 3'b010);
        press(6'd9, 3'b011);
        f = bus.bet_flat;
        chk("three_flat", f[23:0], 24'hC98745);
        chk("three_count", bus.bet_count, 4'd3);
        chk("three_accepts", acc_seen - a0, 3);

        // Held read_data is one event; repeating the same bet is a duplicate.
        async_reset();
        a0 = acc_seen;
        r0 = rej_seen;
        bus.bet_opcode    = 6'd5;
        bus.arduino_color = 3'b001;
        bus.read_data     = 1'b1;
        repeat (10) tick();
        bus.read_data     = 1'b0;
        tick();
        chk("held_one_accept", acc_seen - a0, 1);
        press(6'd5, 3'b001);
        chk("dup_reject", rej_seen - r0, 1);
        chk("dup_count", bus.bet_count, 4'd1);

        // Fill the table, overflow is refused, CLEAR empties it.
        async_reset();
        for (int i = 1; i <= MAX; i++) press(6'(i), 3'b001);
        r0 = rej_seen;
        press(6'd13, 3'b001);
        f = bus.bet_flat;
        chk("overflow_reject", rej_seen - r0, 1);
        chk("overflow_full", bus.full, 1'b1);
        chk("overflow_slot11", f[95:88], 8'h4C);
        a0 = acc_seen;
        press(CLEAR_OP, 3'b000);
        chk("clear_accept", acc_seen - a0, 1);
        chk("clear_count", bus.bet_count, 4'd0);
        chk("clear_flat", bus.bet_flat, 96'd0);

        // SPIN on an empty table is refused; with bets it locks the table.
        r0 = rej_seen;
        press(SPIN_OP, 3'b000);
        chk("spin_empty_reject", rej_seen - r0, 1);
        chk("spin_empty_state", bus.state_dbg, 2'd0);
        press(6'd20, 3'b010);
        press(6'd21, 3'b011);
        bus.bet_opcode = SPIN_OP;
        bus.read_data  = 1'b1;
        tick();
        chk("spin_check_on", bus.spin_check, 1'b1);
        bus.read_data  = 1'b0;
        tick();
        r0 = rej_seen;
        press(6'd22, 3'b001);
        chk("spin_bet_reject", rej_seen - r0, 1);
        chk("spin_bet_count", bus.bet_count, 4'd2);

        // Settle holds the bets exactly HOLD cycles, then reopens empty.
        bus.spin_done = 1'b1;
        tick();
        bus.spin_done = 1'b0;
        chk("settle_state", bus.state_dbg, 2'd2);
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            chk("settle_hold_count", bus.bet_count, 4'd2);
        end
        tick();
        chk("settle_end_count", bus.bet_count, 4'd0);
        chk("settle_end_state", bus.state_dbg, 2'd0);
        chk("settle_end_spin", bus.spin_check, 1'b0);

        // Reset mid-settle, then a new bet goes to slot 0.
        press(6'd3, 3'b001);
        press(SPIN_OP, 3'b000);
        bus.spin_done = 1'b1;
        tick();
        bus.spin_done = 1'b0;
        repeat (3) tick();
        async_reset();
        chk("midreset_count", bus.bet_count, 4'd0);
        press(6'd4, 3'b010);
        f = bus.bet_flat;
        chk("post_reset_slot0", f[7:0], 8'h84);
        chk("post_reset_count", bus.bet_count, 4'd1);

        // Randomized traffic; the model checks every cycle.
        for (int n = 0; n < 1500; n++) begin
            int k;
            k = $urandom_range(0, 31);
            if (k == 30)      bus.bet_opcode = SPIN_OP;
            else if (k == 31) bus.bet_opcode = ($urandom_range(0, 3) == 0) ? CLEAR_OP : SPIN_OP;
            else              bus.bet_opcode = 6'($urandom_range(0, 9));
            bus.arduino_color = 3'($urandom_range(0, 7));
            bus.read_data     = ($urandom_range(0, 1) == 1);
            bus.spin_done     = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
